// File: rtl/serial_subtractor.sv
// Digit-serial signed subtractor: result = a + ~b + 1, DIGIT bits per clock, LSB first.
// Valid/ready on both sides; signed overflow flag with optional clamp to the signed limit.
module serial_subtractor #(
  parameter int WIDTH    = 16,
  parameter int DIGIT    = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sr_q, b_sr_q, result_q;
  logic [CW-1:0]     cnt_q;
  logic              carry_q, a_msb_q, b_msb_q, overflow_q;

  logic [DIGIT-1:0]  sum;
  logic              c;
  logic              carry_d, ovf_d, last;
  logic [WIDTH-1:0]  raw_d, res_d;

  // Ripple of DIGIT full-adder cells over the low digit of both operand registers.
  always_comb begin
    sum = '0;
    c   = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      sum[i] = a_sr_q[i] ^ b_sr_q[i] ^ c;
      c      = (a_sr_q[i] & b_sr_q[i]) | (c & (a_sr_q[i] ^ b_sr_q[i]));
    end
    carry_d = c;
    raw_d   = WIDTH'({sum, result_q} >> DIGIT);
    ovf_d   = (a_msb_q != b_msb_q) && (raw_d[WIDTH-1] != a_msb_q);
    res_d   = raw_d;
    if (SATURATE != 0 && ovf_d)
      res_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    last    = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q  <= a;
            b_sr_q  <= ~b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> DIGIT;
          b_sr_q  <= b_sr_q >> DIGIT;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            result_q   <= res_d;
            overflow_q <= ovf_d;
            state_q    <= DONE;
          end else begin
            result_q <= raw_d;
          end
        end
        DONE: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor; wrapping and saturating
// instances share stimulus and are compared against plain signed arithmetic.
module tb_serial_subtractor;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0, b = '0;
  logic          ir0, ov_v0, ovf0, ir1, ov_v1, ovf1;
  logic [W-1:0]  r0, r1;

  int checks = 0;
  int errors = 0;
  int ops_done = 0;
  int pulses = 0;
  bit prev_v = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W), .DIGIT(2), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .out_valid(ov_v0), .out_ready(out_ready),
    .result(r0), .overflow(ovf0));

  serial_subtractor #(.WIDTH(W), .DIGIT(2), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .out_valid(ov_v1), .out_ready(out_ready),
    .result(r1), .overflow(ovf1));

  always @(posedge clk) begin
    if (ov_v0 && !prev_v) pulses++;
    prev_v <= ov_v0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input bit sat,
                                output logic [W-1:0] res, output logic ov);
    int d;
    d   = int'($signed(ma)) - int'($signed(mb));
    ov  = (d > 32767) || (d < -32768);
    res = d[W-1:0];
    if (sat && ov) res = (d > 0) ? 16'h7FFF : 16'h8000;
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold, input bit junk);
    int n;
    logic [W-1:0] e0, e1;
    logic eo0, eo1;
    n = 0;
    while (!ir0 && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_before", {31'b0, ir0}, 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    check("accept_drop", {31'b0, ir0}, 32'd0);
    if (junk) begin a = $urandom; b = $urandom; end else in_valid = 1'b0;
    n = 0;
    while (!ov_v0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (junk) begin a = $urandom; b = $urandom; end
    end
    in_valid = 1'b0;
    check("latency", n, 32'd8);
    model(ta, tb_v, 1'b0, e0, eo0);
    model(ta, tb_v, 1'b1, e1, eo1);
    check("res_wrap", {16'b0, r0}, {16'b0, e0});
    check("ovf_wrap", {31'b0, ovf0}, {31'b0, eo0});
    check("res_sat", {16'b0, r1}, {16'b0, e1});
    check("ovf_sat", {31'b0, ovf1}, {31'b0, eo1});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = 16'd1; b = 16'd1;
      @(posedge clk); #1;
      check("hold_valid", {31'b0, ov_v0}, 32'd1);
      check("hold_res", {16'b0, r0}, {16'b0, e0});
      check("hold_ready", {31'b0, ir0}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("release", {31'b0, ov_v0}, 32'd0);
    check("ready_back", {31'b0, ir0}, 32'd1);
    ops_done++;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #1;
    check("rst_res", {16'b0, r0}, 32'd0);
    check("rst_ovf", {31'b0, ovf0}, 32'd0);
    check("rst_valid", {31'b0, ov_v0}, 32'd0);
    check("rst_ready", {31'b0, ir0}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(16'd100, 16'd30, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 0, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 0, 1'b0);
    do_op(16'hFFFB, 16'd7, 5, 1'b0);
    do_op(16'd1, 16'd1, 0, 1'b0);

    // Abandon an operation mid-RUN with reset.
    a = 16'd1000; b = 16'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("midrst_valid", {31'b0, ov_v0}, 32'd0);
    check("midrst_res", {16'b0, r0}, 32'd0);
    check("midrst_ovf", {31'b0, ovf0}, 32'd0);
    check("midrst_ready", {31'b0, ir0}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(16'hFFFB, 16'hFFFB, 0, 1'b0);

    do_op(16'h1234, 16'h0234, 0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        1: rb = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: ;
      endcase
      do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("pulse_count", pulses, ops_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
